// File: rtl/memory_island_port_mux.sv
// memory_island_port_mux
//   Funnels NumInp upstream memory request ports onto one memory-island port.
//   A round-robin arbiter picks the requester. Once a request is presented but
//   not yet granted, the arbiter keeps that choice. The index of each accepted
//   request goes into a route FIFO. The island answers in grant order, so the
//   FIFO head tells us which port owns the next response.
//
// Optional feature:
//   MEMORY_ISLAND_PORT_MUX_PERF_CNT_EN - when defined, each port gets a
//   saturating count of its accepted requests. When it is not defined,
//   grant_cnt_o is tied to zero and no counter registers are built.
//
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   in_req_i / in_gnt_o                    per-port request / grant
//   in_addr_i, in_we_i, in_wdata_i,
//   in_strb_i                              per-port request payload
//   in_rvalid_o / in_rdata_o               per-port response
//   out_req_o / out_gnt_i                  island request / grant
//   out_addr_o, out_we_o, out_wdata_o,
//   out_strb_o                             selected payload
//   out_rvalid_i / out_rdata_i             island response (in grant order)
//   grant_cnt_o                            per-port accepted-request counters
module memory_island_port_mux #(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned CntWidth  = 16,
  localparam int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumInp-1:0]                    in_req_i,
  output logic [NumInp-1:0]                    in_gnt_o,
  input  logic [NumInp-1:0][AddrWidth-1:0]     in_addr_i,
  input  logic [NumInp-1:0]                    in_we_i,
  input  logic [NumInp-1:0][DataWidth-1:0]     in_wdata_i,
  input  logic [NumInp-1:0][StrbWidth-1:0]     in_strb_i,
  output logic [NumInp-1:0]                    in_rvalid_o,
  output logic [NumInp-1:0][DataWidth-1:0]     in_rdata_o,
  output logic                                 out_req_o,
  input  logic                                 out_gnt_i,
  output logic [AddrWidth-1:0]                 out_addr_o,
  output logic                                 out_we_o,
  output logic [DataWidth-1:0]                 out_wdata_o,
  output logic [StrbWidth-1:0]                 out_strb_o,
  input  logic                                 out_rvalid_i,
  input  logic [DataWidth-1:0]                 out_rdata_i,
  output logic [NumInp-1:0][CntWidth-1:0]      grant_cnt_o
);

  localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned OccWidth = $clog2(MaxTrans + 1);

  logic [IdxWidth-1:0] sel;
  logic                any_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                accept;
  logic                pop;

  logic [IdxWidth-1:0] fifo_mem [MaxTrans];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [OccWidth-1:0] occ_q;

  assign any_req    = |in_req_i;
  assign fifo_full  = (occ_q == OccWidth'(MaxTrans));
  assign fifo_empty = (occ_q == '0);
  // A full FIFO blocks requests even when a response frees a slot this cycle.
  // This keeps out_req_o off the rvalid path.
  assign out_req_o  = any_req && !fifo_full;
  assign accept     = out_req_o && out_gnt_i;
  // A response that arrives with nothing outstanding is dropped.
  assign pop        = out_rvalid_i && !fifo_empty;

  if (NumInp == 1) begin : g_single
    assign sel = '0;
  end else begin : g_arb
    logic [IdxWidth-1:0] rr_q;
    logic [IdxWidth-1:0] sel_q;
    logic                lock_q;
    logic [IdxWidth-1:0] rr_sel;

    // Search for the first active request, starting at the priority pointer.
    always_comb begin
      int  idx;
      logic found;
      rr_sel = rr_q;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < int'(NumInp); i++) begin
        idx = (int'(rr_q) + i) % int'(NumInp);
        if (!found && in_req_i[idx]) begin
          rr_sel = IdxWidth'(idx);
          found  = 1'b1;
        end
      end
    end

    // A presented request that has not been granted holds the selection.
    // This keeps the payload stable toward the island.
    assign sel = lock_q ? sel_q : rr_sel;

    // After an accept, priority moves to the port just past the winner.
    // The lock is set while the island stalls and cleared when the request is
    // taken. It is also cleared when every requester drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_q   <= '0;
        sel_q  <= '0;
        lock_q <= 1'b0;
      end else if (accept) begin
        rr_q   <= (sel == IdxWidth'(NumInp - 1)) ? '0 : sel + IdxWidth'(1);
        lock_q <= 1'b0;
      end else if (out_req_o) begin
        sel_q  <= sel;
        lock_q <= 1'b1;
      end else if (!any_req) begin
        lock_q <= 1'b0;
      end
    end
  end

  assign out_addr_o  = in_addr_i[sel];
  assign out_we_o    = in_we_i[sel];
  assign out_wdata_o = in_wdata_i[sel];
  assign out_strb_o  = in_strb_i[sel];

  // Only the selected port sees a grant, and only on an accepted cycle.
  always_comb begin
    in_gnt_o = '0;
    if (accept) in_gnt_o[sel] = 1'b1;
  end

  // The FIFO head names the port that owns the response on the bus now.
  always_comb begin
    in_rvalid_o = '0;
    if (pop) in_rvalid_o[fifo_mem[rd_ptr_q]] = 1'b1;
  end

  assign in_rdata_o = {NumInp{out_rdata_i}};

  // The route FIFO storage needs no reset, because occupancy qualifies every read.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem[wr_ptr_q] <= sel;
  end

  // The pointers wrap explicitly, so MaxTrans does not need to be a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (accept)
        wr_ptr_q <= (wr_ptr_q == PtrWidth'(MaxTrans - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
      if (pop)
        rd_ptr_q <= (rd_ptr_q == PtrWidth'(MaxTrans - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
      if (accept && !pop)
        occ_q <= occ_q + OccWidth'(1);
      else if (pop && !accept)
        occ_q <= occ_q - OccWidth'(1);
    end
  end

`ifdef MEMORY_ISLAND_PORT_MUX_PERF_CNT_EN
  logic [NumInp-1:0][CntWidth-1:0] cnt_q;

  // Each port counts its accepted requests. The count saturates at all-ones
  // instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(NumInp); i++) begin
        if (in_gnt_o[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CntWidth'(1);
      end
    end
  end

  assign grant_cnt_o = cnt_q;
`else
  assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_memory_island_port_mux.sv
// tb_memory_island_port_mux
//   Directed bench for memory_island_port_mux using the default 4 ports and
//   4 outstanding slots. CntWidth is set to 4 so that counter saturation is
//   reached quickly. The bench plays the island by hand, cycle by cycle, and
//   compares each output against an expected value written out by hand.
module tb_memory_island_port_mux;

  localparam int NumInp    = 4;
  localparam int AddrWidth = 32;
  localparam int DataWidth = 64;
  localparam int StrbWidth = DataWidth / 8;
  localparam int MaxTrans  = 4;
  localparam int CntWidth  = 4;

`ifdef MEMORY_ISLAND_PORT_MUX_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic                                clk_i = 1'b0;
  logic                                rst_ni;
  logic [NumInp-1:0]                   in_req_i;
  logic [NumInp-1:0]                   in_gnt_o;
  logic [NumInp-1:0][AddrWidth-1:0]    in_addr_i;
  logic [NumInp-1:0]                   in_we_i;
  logic [NumInp-1:0][DataWidth-1:0]    in_wdata_i;
  logic [NumInp-1:0][StrbWidth-1:0]    in_strb_i;
  logic [NumInp-1:0]                   in_rvalid_o;
  logic [NumInp-1:0][DataWidth-1:0]    in_rdata_o;
  logic                                out_req_o;
  logic                                out_gnt_i;
  logic [AddrWidth-1:0]                out_addr_o;
  logic                                out_we_o;
  logic [DataWidth-1:0]                out_wdata_o;
  logic [StrbWidth-1:0]                out_strb_o;
  logic                                out_rvalid_i;
  logic [DataWidth-1:0]                out_rdata_i;
  logic [NumInp-1:0][CntWidth-1:0]     grant_cnt_o;

  int checkCount = 0;
  int errorCount = 0;

  memory_island_port_mux #(
    .NumInp   (NumInp),
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth),
    .MaxTrans (MaxTrans),
    .CntWidth (CntWidth)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_req_i    (in_req_i),
    .in_gnt_o    (in_gnt_o),
    .in_addr_i   (in_addr_i),
    .in_we_i     (in_we_i),
    .in_wdata_i  (in_wdata_i),
    .in_strb_i   (in_strb_i),
    .in_rvalid_o (in_rvalid_o),
    .in_rdata_o  (in_rdata_o),
    .out_req_o   (out_req_o),
    .out_gnt_i   (out_gnt_i),
    .out_addr_o  (out_addr_o),
    .out_we_o    (out_we_o),
    .out_wdata_o (out_wdata_o),
    .out_strb_o  (out_strb_o),
    .out_rvalid_i(out_rvalid_i),
    .out_rdata_i (out_rdata_i),
    .grant_cnt_o (grant_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [AddrWidth-1:0] expAddr(input int p);
    return 32'h1000_0000 + 32'(p) * 32'h40;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expVal);
    checkCount++;
    if (obs !== expVal) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expVal);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge. Outputs are then
  // read 1 time unit later, well before the rising edge.
  task automatic applyStimulus(input logic [3:0] req, input logic gnt,
                               input logic rv, input logic [63:0] rd);
    @(negedge clk_i);
    in_req_i     = req;
    out_gnt_i    = gnt;
    out_rvalid_i = rv;
    out_rdata_i  = rd;
    #1;
  endtask

  task automatic checkHandshake(input string tag, input logic reqExp,
                                input logic [3:0] gntExp, input logic [3:0] rvExp);
    checkOutput({tag, "_out_req"}, 64'(out_req_o), 64'(reqExp));
    checkOutput({tag, "_gnt"}, 64'(in_gnt_o), 64'(gntExp));
    checkOutput({tag, "_rvalid"}, 64'(in_rvalid_o), 64'(rvExp));
  endtask

  initial begin
    for (int i = 0; i < NumInp; i++) begin
      in_addr_i[i]  = expAddr(i);
      in_we_i[i]    = i[0];
      in_wdata_i[i] = 64'hCAFE_0000_0000_0000 | 64'(i);
      in_strb_i[i]  = 8'h01 << i;
    end
    in_req_i     = '0;
    out_gnt_i    = 1'b0;
    out_rvalid_i = 1'b0;
    out_rdata_i  = '0;
    rst_ni       = 1'b0;
    #1;
    checkHandshake("reset", 1'b0, 4'b0000, 4'b0000);
    checkOutput("reset_cnt1", 64'(grant_cnt_o[1]), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // All ports request while the island grants every cycle. Each response
    // comes one cycle after its grant.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'hF, 1'b1, k > 0, 64'hD000 + 64'(k));
      checkHandshake($sformatf("rr%0d", k), 1'b1, 4'(1 << (k % 4)),
                     (k > 0) ? 4'(1 << ((k - 1) % 4)) : 4'b0000);
      checkOutput($sformatf("rr%0d_addr", k), 64'(out_addr_o), 64'(expAddr(k % 4)));
      if (k == 1) begin
        checkOutput("rr1_we", 64'(out_we_o), 64'd1);
        checkOutput("rr1_wdata", out_wdata_o, 64'hCAFE_0000_0000_0001);
        checkOutput("rr1_strb", 64'(out_strb_o), 64'h02);
        checkOutput("rr1_rdata3", in_rdata_o[3], 64'hD001);
        checkOutput("rr1_rdata0", in_rdata_o[0], 64'hD001);
      end
    end
    applyStimulus(4'h0, 1'b0, 1'b1, 64'hD005);
    checkHandshake("rr_tail", 1'b0, 4'b0000, 4'b0001);

    // A response that arrives with nothing outstanding must be ignored.
    applyStimulus(4'h0, 1'b0, 1'b1, 64'hBAD0);
    checkHandshake("stray_empty", 1'b0, 4'b0000, 4'b0000);

    // Port 2 goes alone first, which moves priority to port 3.
    applyStimulus(4'b0100, 1'b1, 1'b0, 64'h0);
    checkHandshake("pre_lock", 1'b1, 4'b0100, 4'b0000);
    // Port 2 now stalls, so the selection stays locked on it. Port 0
    // (priority 3 -> 0 -> 1 -> 2) would otherwise win from cycle 1.
    applyStimulus(4'b0100, 1'b0, 1'b1, 64'h0);
    checkHandshake("lock0", 1'b1, 4'b0000, 4'b0100);
    checkOutput("lock0_addr", 64'(out_addr_o), 64'(expAddr(2)));
    for (int k = 1; k < 3; k++) begin
      applyStimulus(4'b0101, 1'b0, 1'b0, 64'h0);
      checkOutput($sformatf("lock%0d_addr", k), 64'(out_addr_o), 64'(expAddr(2)));
      checkOutput($sformatf("lock%0d_gnt", k), 64'(in_gnt_o), 64'h0);
    end
    applyStimulus(4'b0101, 1'b1, 1'b0, 64'h0);
    checkHandshake("lock_acc", 1'b1, 4'b0100, 4'b0000);
    checkOutput("lock_acc_addr", 64'(out_addr_o), 64'(expAddr(2)));
    applyStimulus(4'b0001, 1'b1, 1'b0, 64'h0);
    checkHandshake("after_lock", 1'b1, 4'b0001, 4'b0000);
    applyStimulus(4'h0, 1'b0, 1'b1, 64'h0);
    checkHandshake("lock_rsp0", 1'b0, 4'b0000, 4'b0100);
    applyStimulus(4'h0, 1'b0, 1'b1, 64'h0);
    checkHandshake("lock_rsp1", 1'b0, 4'b0000, 4'b0001);

    // Fill all 4 slots from port 1 while the island holds its responses.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0010, 1'b1, 1'b0, 64'h0);
      checkHandshake($sformatf("fill%0d", k), 1'b1, 4'b0010, 4'b0000);
    end
    applyStimulus(4'b0010, 1'b1, 1'b0, 64'h0);
    checkHandshake("full", 1'b0, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 1'b1, 1'b1, 64'h0);
    checkHandshake("full_pop", 1'b0, 4'b0000, 4'b0010);
    applyStimulus(4'b0010, 1'b1, 1'b0, 64'h0);
    checkHandshake("refill", 1'b1, 4'b0010, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'h0, 1'b0, 1'b1, 64'h0);
      checkHandshake($sformatf("drain%0d", k), 1'b0, 4'b0000, 4'b0010);
    end

    // Leave 3 requests outstanding, then reset while they are in flight.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0010, 1'b1, 1'b0, 64'h0);
      checkHandshake($sformatf("pre_rst%0d", k), 1'b1, 4'b0010, 4'b0000);
    end
    @(negedge clk_i);
    rst_ni       = 1'b0;
    in_req_i     = '0;
    out_gnt_i    = 1'b0;
    out_rvalid_i = 1'b1;
    #1;
    checkHandshake("mid_rst", 1'b0, 4'b0000, 4'b0000);
    checkOutput("mid_rst_cnt1", 64'(grant_cnt_o[1]), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'h0, 1'b0, 1'b1, 64'hBAD1);
      checkHandshake($sformatf("post_rst_stray%0d", k), 1'b0, 4'b0000, 4'b0000);
    end
    // An empty FIFO and a priority pointer back at 0 give grants 0..3 and then full.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'hF, 1'b1, 1'b0, 64'h0);
      checkHandshake($sformatf("post_rst%0d", k), 1'b1, 4'(1 << k), 4'b0000);
    end
    applyStimulus(4'hF, 1'b1, 1'b0, 64'h0);
    checkHandshake("post_rst_full", 1'b0, 4'b0000, 4'b0000);
    checkOutput("cnt1_one", 64'(grant_cnt_o[1]), PerfEn ? 64'd1 : 64'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'h0, 1'b0, 1'b1, 64'h0);
      checkHandshake($sformatf("post_rst_drain%0d", k), 1'b0, 4'b0000, 4'(1 << k));
    end

    // Port 1 is accepted 20 more times, so its 4-bit counter saturates.
    applyStimulus(4'b0010, 1'b1, 1'b0, 64'h0);
    checkHandshake("sat_first", 1'b1, 4'b0010, 4'b0000);
    for (int k = 0; k < 19; k++) begin
      applyStimulus(4'b0010, 1'b1, 1'b1, 64'h0);
      checkOutput($sformatf("sat%0d_gnt", k), 64'(in_gnt_o), 64'h2);
      checkOutput($sformatf("sat%0d_rvalid", k), 64'(in_rvalid_o), 64'h2);
    end
    applyStimulus(4'h0, 1'b0, 1'b1, 64'h0);
    checkHandshake("sat_tail", 1'b0, 4'b0000, 4'b0010);
    checkOutput("cnt1_sat", 64'(grant_cnt_o[1]), PerfEn ? 64'd15 : 64'd0);
    checkOutput("cnt0", 64'(grant_cnt_o[0]), PerfEn ? 64'd1 : 64'd0);
    checkOutput("cnt2", 64'(grant_cnt_o[2]), PerfEn ? 64'd1 : 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
